// File: rtl/vga_timing_gen.sv
// Raster timing generator: hsync/vsync/de, pixel coordinates, line/frame strobes
// and a free-running frame counter. The sync/de decode runs on the next-state
// counter values so every registered output describes the registered xpos/ypos.
module vga_timing_gen #(
  parameter int unsigned H_VIS  = 640,
  parameter int unsigned H_FP   = 16,
  parameter int unsigned H_SYNC = 96,
  parameter int unsigned H_BP   = 48,
  parameter int unsigned V_VIS  = 480,
  parameter int unsigned V_FP   = 10,
  parameter int unsigned V_SYNC = 2,
  parameter int unsigned V_BP   = 33,
  parameter bit          HS_ACT = 1'b0,
  parameter bit          VS_ACT = 1'b0,
  parameter int unsigned CW     = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [CW-1:0] xpos,
  output logic [CW-1:0] ypos,
  output logic          line_start,
  output logic          frame_start,
  output logic [7:0]    frame_cnt
);

  localparam int unsigned H_TOTAL  = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_BEG   = H_VIS + H_FP;
  localparam int unsigned HS_END   = HS_BEG + H_SYNC;
  localparam int unsigned VS_BEG   = V_VIS + V_FP;
  localparam int unsigned VS_END   = VS_BEG + V_SYNC;

  localparam logic [CW-1:0] X_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] Y_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] X_VIS    = CW'(H_VIS);
  localparam logic [CW-1:0] Y_VIS    = CW'(V_VIS);
  localparam logic [CW-1:0] X_HS_BEG = CW'(HS_BEG);
  localparam logic [CW-1:0] X_HS_END = CW'(HS_END);
  localparam logic [CW-1:0] Y_VS_BEG = CW'(VS_BEG);
  localparam logic [CW-1:0] Y_VS_END = CW'(VS_END);

  logic [CW-1:0] x_nxt;
  logic [CW-1:0] y_nxt;
  logic          x_wrap;
  logic          hs_nxt;
  logic          vs_nxt;
  logic          de_nxt;
  logic          ls_nxt;
  logic          fs_nxt;

  // Next raster position: x wraps at end of line, y advances (and wraps) on x wrap
  always_comb begin
    x_nxt  = xpos + CW'(1);
    y_nxt  = ypos;
    x_wrap = (xpos == X_LAST);
    if (x_wrap) begin
      x_nxt = '0;
      if (ypos == Y_LAST) begin
        y_nxt = '0;
      end else begin
        y_nxt = ypos + CW'(1);
      end
    end
  end

  // Decode of the next position, registered alongside the counters
  always_comb begin
    de_nxt = (x_nxt < X_VIS) && (y_nxt < Y_VIS);
    hs_nxt = ~HS_ACT;
    vs_nxt = ~VS_ACT;
    if ((x_nxt >= X_HS_BEG) && (x_nxt < X_HS_END)) begin
      hs_nxt = HS_ACT;
    end
    if ((y_nxt >= Y_VS_BEG) && (y_nxt < Y_VS_END)) begin
      vs_nxt = VS_ACT;
    end
    ls_nxt = (x_nxt == '0);
    fs_nxt = (x_nxt == '0) && (y_nxt == '0);
  end

  // Raster state; reset parks on the last pixel so the first enabled edge hits (0,0)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xpos        <= X_LAST;
      ypos        <= Y_LAST;
      hsync       <= ~HS_ACT;
      vsync       <= ~VS_ACT;
      de          <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_cnt   <= 8'd0;
    end else if (en) begin
      xpos        <= x_nxt;
      ypos        <= y_nxt;
      hsync       <= hs_nxt;
      vsync       <= vs_nxt;
      de          <= de_nxt;
      line_start  <= ls_nxt;
      frame_start <= fs_nxt;
      if (fs_nxt) begin
        frame_cnt <= frame_cnt + 8'd1;
      end
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Pixel-rate raster timing generator, the stage directly upstream of the pixel/colour logic. It produces hsync, vsync, data-enable, the current pixel coordinates and frame/line strobes. Downstream colour logic consumes xpos/ypos and de on the same clock edge. Default timing is 640x480@60 (25.175 MHz nominal pixel clock). An optional clock enable lets it run from a faster system clock.

Parameters:
H_VIS, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_VIS, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
HS_ACT, 0, active level of hsync
VS_ACT, 0, active level of vsync
CW, 10, coordinate counter width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
clk  input  1  pixel/system clock
rst_n  input  1  asynchronous active-low reset
en  input  1  pixel advance enable; tie to 1 when clk is the pixel clock
hsync  output  1  horizontal sync, registered
vsync  output  1  vertical sync, registered
de  output  1  high while (xpos,ypos) is inside the visible area
xpos  output  CW  horizontal counter, 0..H_TOTAL-1
ypos  output  CW  vertical counter, 0..V_TOTAL-1
line_start  output  1  one-clk strobe when xpos enters 0
frame_start  output  1  one-clk strobe when (xpos,ypos) enters (0,0)
frame_cnt  output  8  frame counter, wraps 255->0

Behaviour:
- Totals: H_TOTAL = H_VIS+H_FP+H_SYNC+H_BP (default 800); V_TOTAL = V_VIS+V_FP+V_SYNC+V_BP (default 525).
- One clock domain, all outputs registered, no combinational input-to-output paths.
- Reset (rst_n low, asynchronous assertion):
  - xpos = H_TOTAL-1 (799), ypos = V_TOTAL-1 (524).
  - hsync = ~HS_ACT, vsync = ~VS_ACT.
  - de = 0, line_start = 0, frame_start = 0, frame_cnt = 0.
  - The reset state is the last pixel of a frame, so the first enabled edge after release lands on (0,0).
- Advance (en=1 at a clk edge):
  - xpos increments. At H_TOTAL-1, xpos wraps to 0 and ypos increments.
  - At ypos = V_TOTAL-1 with xpos wrapping, ypos wraps to 0.
- en=0: counters, hsync, vsync, de and frame_cnt hold; line_start and frame_start forced to 0.
- Decode is computed from next-state counter values and registered, so hsync/vsync/de are exactly aligned with the xpos/ypos they describe (zero skew, no extra latency):
  - de = (xpos < H_VIS) && (ypos < V_VIS).
  - hsync = HS_ACT when H_VIS+H_FP <= xpos < H_VIS+H_FP+H_SYNC (656..751), else ~HS_ACT.
  - vsync = VS_ACT when V_VIS+V_FP <= ypos < V_VIS+V_FP+V_SYNC (490..491), else ~VS_ACT. vsync is a function of ypos only and changes on the xpos=0 boundary.
- line_start: 1 for exactly one clk after an enabled edge that produced xpos=0; 0 otherwise.
- frame_start: 1 for exactly one clk after an enabled edge that produced (0,0). It coincides with line_start.
- frame_cnt: increments on the same edge that raises frame_start; 255 -> 0.
- Reset mid-frame: all outputs return immediately to reset values; no partial sync pulse is extended.
- en toggling every cycle must yield identical output sequences, sampled on enabled edges, to en=1 operation.

Test Plan:
- Reset release, en=1 -> first edge: xpos=0, ypos=0, de=1, frame_start=1, line_start=1, frame_cnt=1; next edge: frame_start=0, xpos=1.
- Run one line -> de high for xpos 0..639 (640 clks); hsync low for xpos 656..751 (96 clks); line_start period 800 clks.
- Run two full frames -> vsync low for ypos 490..491 (1600 clks), falling on the edge xpos=0/ypos=490; frame_start period 420000 clks; frame_cnt=2 at second (0,0).
- en toggled 1,0,1,0... -> on each enabled edge, outputs match the en=1 reference trace; strobes are one clk wide; outputs hold on en=0 cycles.
- Assert rst_n low at xpos=700, ypos=300 (inside hsync) -> hsync=1, de=0, xpos=799, ypos=524 immediately without waiting for a clk edge; normal restart after release.
- frame_cnt wrap: run 256 frames (or force via a small-timing parameter set, H_VIS=4, H_FP=1, H_SYNC=1, H_BP=1, V_VIS=2, V_FP=1, V_SYNC=1, V_BP=1) -> frame_cnt goes 255->0 on the frame_start edge.
